// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode encoding, FSM state
// encoding and bit positions inside the 5-bit flags vector.
package alu_pkg;

    // Operation select carried on the opcode input; 1100-1111 are illegal.
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_XOR = 4'b0010,
        OP_ADD = 4'b0011,
        OP_SUB = 4'b0100,
        OP_MUL = 4'b0101,
        OP_DIV = 4'b0110,
        OP_REM = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_ROL = 4'b1010,
        OP_ROR = 4'b1011
    } alu_op_e;

    // Top-level control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // flags = {illegal_op, div_by_zero, zero, overflow, carry_out}
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_DIVZ  = 3;
    localparam int FLAG_ILL   = 4;
    localparam int FLAG_W     = 5;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// Both operations share one 2*WIDTH accumulator {hi, lo}:
//   MUL: lo starts as the multiplier, hi accumulates; ends as {prod_hi, prod_lo}.
//   DIV: lo starts as the dividend, hi is the partial remainder; ends as
//        {remainder, quotient}.
// start_i loads the operands; exactly WIDTH iteration cycles follow. done_o
// is high during the final iteration cycle and prod_o shows the accumulator
// value that this cycle's clock edge will store, so the caller can capture
// the finished result on that same edge.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;

    // One iteration step of either the shift-add multiplier or the restoring divider.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        // Shift the remainder left by one, pulling in the next dividend bit.
        div_diff = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        acc_d    = acc_q;
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // Operand load on start, then WIDTH counted iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= is_div_i;
            opnd_q   <= b_i;
            acc_q    <= {{WIDTH{1'b0}}, a_i};
        end else if (busy_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == LAST);
    assign prod_o = acc_d;

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: logic, add/sub, shifts and rotates complete in one cycle;
// MUL/DIV/REM iterate one bit per cycle in alu_muldiv_iter.
// Optional feature macro: MULTICYCLE_ALU_MULDIV_EN. When it is not defined,
// MUL/DIV/REM decode as illegal and no multiply/divide hardware is built.
// Handshake: a request is taken on a clock edge where in_valid && in_ready;
// in_ready is high only in IDLE. A result is presented with out_valid and
// held stable until a clock edge with out_ready high, after which the block
// returns to IDLE (it cannot take a new request on that same edge).
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic [FLAG_W-1:0]  flags,
    output alu_state_e         dbg_state_o
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic [FLAG_W-1:0]  flags_q;

    // Single-cycle datapath, evaluated directly on the request inputs.
    logic [WIDTH-1:0]   sc_result;
    logic [WIDTH-1:0]   sc_hi;
    logic [FLAG_W-1:0]  sc_flags;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [SHW-1:0]     sh_amt;

    assign sh_amt = b[SHW-1:0];

    // Result and flags for every operation that finishes in one cycle.
    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_flags  = '0;
        add_sum   = {1'b0, a} + {1'b0, b};
        sub_diff  = {1'b0, a} - {1'b0, b};
        case (opcode)
            OP_AND: sc_result = a & b;
            OP_OR:  sc_result = a | b;
            OP_XOR: sc_result = a ^ b;
            OP_ADD: begin
                sc_result           = add_sum[WIDTH-1:0];
                sc_flags[FLAG_CARRY] = add_sum[WIDTH];
                sc_flags[FLAG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                       (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result           = sub_diff[WIDTH-1:0];
                // No borrow out of the top bit means a >= b unsigned.
                sc_flags[FLAG_CARRY] = ~sub_diff[WIDTH];
                sc_flags[FLAG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                       (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL: sc_result = a << sh_amt;
            OP_SRL: sc_result = a >> sh_amt;
            // A shift by WIDTH yields zero, so amount 0 leaves a unchanged.
            OP_ROL: sc_result = (a << sh_amt) | (a >> (WIDTH - int'(sh_amt)));
            OP_ROR: sc_result = (a >> sh_amt) | (a << (WIDTH - int'(sh_amt)));
`ifdef MULTICYCLE_ALU_MULDIV_EN
            // Only reached with b == 0; nonzero divisors go through the iterator.
            OP_DIV: begin
                sc_result           = '1;
                sc_hi               = a;
                sc_flags[FLAG_DIVZ] = 1'b1;
            end
            OP_REM: begin
                sc_result           = a;
                sc_flags[FLAG_DIVZ] = 1'b1;
            end
`endif
            default: sc_flags[FLAG_ILL] = 1'b1;
        endcase
        sc_flags[FLAG_ZERO] = (sc_result == '0);
    end

`ifdef MULTICYCLE_ALU_MULDIV_EN
    logic               go_busy;
    logic               iter_start;
    logic               iter_busy;
    logic               iter_done;
    logic [2*WIDTH-1:0] iter_prod;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   md_result;
    logic [WIDTH-1:0]   md_hi;
    logic [FLAG_W-1:0]  md_flags;

    assign go_busy    = (opcode == OP_MUL) ||
                        (((opcode == OP_DIV) || (opcode == OP_REM)) && (b != '0));
    assign iter_start = in_valid && (state_q == ST_IDLE) && go_busy;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (iter_start),
        .is_div_i (opcode != OP_MUL),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (iter_busy),
        .done_o   (iter_done),
        .prod_o   (iter_prod)
    );

    // MUL and DIV share the {hi, lo} layout; REM moves the remainder down.
    always_comb begin
        md_result = iter_prod[WIDTH-1:0];
        md_hi     = iter_prod[2*WIDTH-1:WIDTH];
        if (op_q == OP_REM) begin
            md_result = iter_prod[2*WIDTH-1:WIDTH];
            md_hi     = '0;
        end
        md_flags            = '0;
        md_flags[FLAG_ZERO] = (md_result == '0);
    end
`endif

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
            op_q        <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
                        op_q <= opcode;
                        if (go_busy) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= sc_result;
                            result_hi_q <= sc_hi;
                            flags_q     <= sc_flags;
                        end
`else
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= sc_result;
                        result_hi_q <= sc_hi;
                        flags_q     <= sc_flags;
`endif
                    end
                end
                ST_BUSY: begin
`ifdef MULTICYCLE_ALU_MULDIV_EN
                    // Capture the final iteration on the edge that completes it.
                    if (iter_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_result;
                        result_hi_q <= md_hi;
                        flags_q     <= md_flags;
                    end else if (!iter_busy) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                    end
`else
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign flags       = flags_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed testbench for multicycle_alu at WIDTH=32. Expected values are
// hand-computed constants. MUL/DIV/REM expectations follow the
// MULTICYCLE_ALU_MULDIV_EN setting of the build.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    opcode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic [4:0]    flags;
    alu_state_e    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .flags       (flags),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, keep junk on the inputs while it is in flight, and
    // check latency, in_ready low while waiting, and the delivered result.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input int exp_lat, input logic [W-1:0] exp_res,
                          input logic [W-1:0] exp_hi, input logic [4:0] exp_flags);
        int lat;
        bit ready_seen;
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = op;
        a        = aa;
        b        = bb;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = $urandom;
        b        = $urandom;
        opcode   = 4'($urandom_range(0, 15));
        lat        = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready) ready_seen = 1'b1;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " in_ready"}, 64'(ready_seen), 64'd0);
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " result_hi"}, 64'(result_hi), 64'(exp_hi));
        check({tag, " flags"}, 64'(flags), 64'(exp_flags));
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " release out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " release in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic op(input string tag, input logic [3:0] opc,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input int exp_lat, input logic [W-1:0] exp_res,
                      input logic [W-1:0] exp_hi, input logic [4:0] exp_flags);
        run_op(tag, opc, aa, bb, exp_lat, exp_res, exp_hi, exp_flags);
        release_result(tag);
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset result_hi", 64'(result_hi), 64'd0);
        check("reset flags", 64'(flags), 64'd0);
        check("reset state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // flags = {ill, divz, zero, ovf, carry}
        op("add_ovf",  4'b0011, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 32'h0, 5'b00010);
        op("add_cy",   4'b0011, 32'hFFFFFFFF, 32'h1, 1, 32'h0,        32'h0, 5'b00101);
        op("sub_eq",   4'b0100, 32'd5,        32'd5, 1, 32'h0,        32'h0, 5'b00101);
        op("sub_brw",  4'b0100, 32'd0,        32'd1, 1, 32'hFFFFFFFF, 32'h0, 5'b00000);
        op("sub_ovf",  4'b0100, 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 32'h0, 5'b00011);
        op("and",      4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'h00F000F0, 32'h0, 5'b00000);
        op("or",       4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'hFFF0FFF0, 32'h0, 5'b00000);
        op("xor",      4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'hFF00FF00, 32'h0, 5'b00000);
        op("sll31",    4'b1000, 32'h1,        32'd31, 1, 32'h80000000, 32'h0, 5'b00000);
        op("sll0",     4'b1000, 32'h12345678, 32'h20, 1, 32'h12345678, 32'h0, 5'b00000);
        op("srl4",     4'b1001, 32'h80000000, 32'd4,  1, 32'h08000000, 32'h0, 5'b00000);
        op("rol1",     4'b1010, 32'h80000001, 32'd1,  1, 32'h00000003, 32'h0, 5'b00000);
        op("ror0",     4'b1011, 32'hCAFEF00D, 32'h40, 1, 32'hCAFEF00D, 32'h0, 5'b00000);
        op("illegal",  4'b1100, 32'h1234,     32'h5678, 1, 32'h0, 32'h0, 5'b10100);
        op("illegalF", 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0, 32'h0, 5'b10100);

        // ROR then hold the result with out_ready low
        run_op("ror1", 4'b1011, 32'h1, 32'd1, 1, 32'h80000000, 32'h0, 5'b00000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold out_valid", 64'(out_valid), 64'd1);
            check("hold result", 64'(result), 64'h80000000);
            check("hold in_ready", 64'(in_ready), 64'd0);
        end
        release_result("ror1");

`ifdef MULTICYCLE_ALU_MULDIV_EN
        op("mul",      4'b0101, 32'hFFFFFFFF, 32'd2, 33, 32'hFFFFFFFE, 32'h1, 5'b00000);
        op("mul_zero", 4'b0101, 32'h0,        32'd5, 33, 32'h0,        32'h0, 5'b00100);
        op("mul_big",  4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'hFFFFFFFE, 5'b00000);
        op("div",      4'b0110, 32'd100,      32'd7, 33, 32'd14,       32'd2, 5'b00000);
        op("div_z",    4'b0110, 32'd9,        32'd0, 1,  32'hFFFFFFFF, 32'd9, 5'b01000);
        op("rem",      4'b0111, 32'd100,      32'd7, 33, 32'd2,        32'd0, 5'b00000);
        op("rem_z",    4'b0111, 32'd9,        32'd0, 1,  32'd9,        32'd0, 5'b01000);
        op("div_big",  4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'd1, 32'd0, 5'b00000);

        // Reset in the middle of a MUL
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 4'b0101;
        a        = 32'hFFFFFFFF;
        b        = 32'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midop state busy", 64'(dbg_state), 64'(ST_BUSY));
`else
        op("mul_ill",  4'b0101, 32'hFFFFFFFF, 32'd2, 1, 32'h0, 32'h0, 5'b10100);
        op("div_ill",  4'b0110, 32'd100,      32'd7, 1, 32'h0, 32'h0, 5'b10100);
        op("rem_ill",  4'b0111, 32'd9,        32'd0, 1, 32'h0, 32'h0, 5'b10100);

        // Reset while a result waits in DONE
        run_op("pre_rst", 4'b0011, 32'd2, 32'd3, 1, 32'd5, 32'h0, 5'b00000);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midop state done", 64'(dbg_state), 64'(ST_DONE));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("midop rst out_valid", 64'(out_valid), 64'd0);
        check("midop rst in_ready", 64'(in_ready), 64'd1);
        check("midop rst state", 64'(dbg_state), 64'(ST_IDLE));
        check("midop rst result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("no result after reset", 64'(seen), 64'd0);

        // Normal operation resumes
        op("post_rst", 4'b0010, 32'hAAAA5555, 32'hFFFF0000, 1, 32'h55555555, 32'h0, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
